// File: rtl/pc_fetch_unit_pkg.sv
// Shared types and constants for the fetch PC generator and its branch target buffer.
package rv_pc_pkg;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        FAULT
    } fsm_state_t;

    // Entry fields are sized for the widest supported XLEN; narrower tags are zero-extended.
    localparam int unsigned BTB_FIELD_W = 32;

    typedef struct packed {
        logic                   valid;
        logic [BTB_FIELD_W-1:0] tag;
        logic [BTB_FIELD_W-1:0] target;
        logic [1:0]             ctr;
    } btb_entry_t;

    localparam logic [1:0] WEAK_TAKEN = 2'b10;
    localparam logic [1:0] SAT_MAX    = 2'b11;

    function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic taken);
        if (taken) begin
            return (ctr == SAT_MAX) ? SAT_MAX : ctr + 2'd1;
        end
        return (ctr == 2'b00) ? 2'b00 : ctr - 2'd1;
    endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Control/observation bundle between the pipeline and the fetch PC generator.
interface pc_fetch_unit_if #(
    parameter int unsigned XLEN = 32
);
    logic            stall_i;
    logic            redirect_i;
    logic [XLEN-1:0] redirect_pc_i;
    logic            upd_valid_i;
    logic [XLEN-1:0] upd_pc_i;
    logic            upd_taken_i;
    logic [XLEN-1:0] upd_target_i;
    logic [XLEN-1:0] pc_o;
    logic [XLEN-1:0] pc_plus4_o;
    logic            fetch_valid_o;
    logic            pred_taken_o;
    logic [XLEN-1:0] pred_target_o;
    logic            misalign_o;

    modport master (
        output stall_i, redirect_i, redirect_pc_i,
        output upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i,
        input  pc_o, pc_plus4_o, fetch_valid_o, pred_taken_o, pred_target_o, misalign_o
    );

    modport slave (
        input  stall_i, redirect_i, redirect_pc_i,
        input  upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i,
        output pc_o, pc_plus4_o, fetch_valid_o, pred_taken_o, pred_target_o, misalign_o
    );
endinterface

// File: rtl/pc_fetch_unit_btb.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
module pc_btb
    import rv_pc_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned BTB_ENTRIES = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] lookup_pc_i,
    input  logic [XLEN-1:0] lookup_pc_plus4_i,
    output logic            pred_taken_o,
    output logic [XLEN-1:0] pred_target_o,
    input  logic            upd_valid_i,
    input  logic [XLEN-1:0] upd_pc_i,
    input  logic            upd_taken_i,
    input  logic [XLEN-1:0] upd_target_i
);
    localparam int unsigned IDX_W = $clog2(BTB_ENTRIES);
    localparam int unsigned TAG_W = XLEN - IDX_W - 2;

    btb_entry_t       entries_q [BTB_ENTRIES];
    btb_entry_t       entries_d [BTB_ENTRIES];
    logic [IDX_W-1:0] lk_idx;
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] lk_tag;
    logic [TAG_W-1:0] upd_tag;
    btb_entry_t       lk_ent;
    btb_entry_t       upd_ent;
    logic             lk_hit;
    logic             upd_hit;
    logic [3:0]       unused_low_bits;

    assign lk_idx          = lookup_pc_i[IDX_W+1:2];
    assign lk_tag          = lookup_pc_i[XLEN-1:IDX_W+2];
    assign upd_idx         = upd_pc_i[IDX_W+1:2];
    assign upd_tag         = upd_pc_i[XLEN-1:IDX_W+2];
    assign unused_low_bits = {lookup_pc_i[1:0], upd_pc_i[1:0]};

    // Lookup reads the registered array, so a same-cycle update is not visible yet.
    assign lk_ent        = entries_q[lk_idx];
    assign lk_hit        = lk_ent.valid && (lk_ent.tag == BTB_FIELD_W'(lk_tag));
    assign pred_taken_o  = lk_hit && lk_ent.ctr[1];
    assign pred_target_o = lk_hit ? lk_ent.target[XLEN-1:0] : lookup_pc_plus4_i;

    always_comb begin
        entries_d = entries_q;
        upd_ent   = entries_q[upd_idx];
        upd_hit   = upd_ent.valid && (upd_ent.tag == BTB_FIELD_W'(upd_tag));
        if (upd_valid_i) begin
            if (upd_hit) begin
                entries_d[upd_idx].ctr = ctr_step(upd_ent.ctr, upd_taken_i);
                if (upd_taken_i) begin
                    entries_d[upd_idx].target = BTB_FIELD_W'(upd_target_i);
                end
            end else if (upd_taken_i) begin
                entries_d[upd_idx] = '{
                    valid:  1'b1,
                    tag:    BTB_FIELD_W'(upd_tag),
                    target: BTB_FIELD_W'(upd_target_i),
                    ctr:    WEAK_TAKEN
                };
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < BTB_ENTRIES; i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            entries_q <= entries_d;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter, boot/run/fault sequencing and next-PC selection ahead of instruction fetch.
module pc_fetch_unit
    import rv_pc_pkg::*;
#(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int unsigned     BTB_ENTRIES  = 16
) (
    input logic            clk,
    input logic            rst,
    pc_fetch_unit_if.slave bus
);
    fsm_state_t      state_q;
    fsm_state_t      state_d;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    logic            fetch_valid_q;
    logic            fetch_valid_d;
    logic            misalign_q;
    logic            misalign_d;
    logic [XLEN-1:0] pc_plus4;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;

    assign pc_plus4 = pc_q + XLEN'(4);

    pc_btb #(
        .XLEN        (XLEN),
        .BTB_ENTRIES (BTB_ENTRIES)
    ) u_btb (
        .clk               (clk),
        .rst               (rst),
        .lookup_pc_i       (pc_q),
        .lookup_pc_plus4_i (pc_plus4),
        .pred_taken_o      (pred_taken),
        .pred_target_o     (pred_target),
        .upd_valid_i       (bus.upd_valid_i),
        .upd_pc_i          (bus.upd_pc_i),
        .upd_taken_i       (bus.upd_taken_i),
        .upd_target_i      (bus.upd_target_i)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        if (bus.redirect_i) begin
            pc_d    = bus.redirect_pc_i;
            state_d = (bus.redirect_pc_i[1:0] == 2'b00) ? RUN : FAULT;
        end else begin
            unique case (state_q)
                BOOT:    state_d = RUN;
                RUN:     if (!bus.stall_i) pc_d = pred_taken ? pred_target : pc_plus4;
                FAULT:   state_d = FAULT;
                default: state_d = BOOT;
            endcase
        end
        // Flags follow the next state so they are registered alongside it.
        fetch_valid_d = (state_d == RUN);
        misalign_d    = (state_d == FAULT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= BOOT;
            pc_q          <= RESET_VECTOR;
            fetch_valid_q <= 1'b0;
            misalign_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            fetch_valid_q <= fetch_valid_d;
            misalign_q    <= misalign_d;
        end
    end

    assign bus.pc_o          = pc_q;
    assign bus.pc_plus4_o    = pc_plus4;
    assign bus.fetch_valid_o = fetch_valid_q;
    assign bus.misalign_o    = misalign_q;
    assign bus.pred_taken_o  = pred_taken;
    assign bus.pred_target_o = pred_target;

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
Parametrised program-counter and next-PC generator for the pipelined RV32I core, placed ahead of instruction fetch. It adds fetch stall, EX-stage redirect (flush), and a direct-mapped branch target buffer (BTB) with 2-bit saturating counters. It also adds a boot cycle and a misaligned-target fault state. The pipeline resolves branch, JAL and JALR in EX and reports outcomes back through the BTB update port.

Parameters:
XLEN, 32, datapath/PC width
RESET_VECTOR, 32'h0000_0000, PC value after reset
BTB_ENTRIES, 16, BTB depth; power of two, >= 2

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
stall_i  in  1  hold PC (fetch/decode back-pressure)
redirect_i  in  1  EX flush; load redirect_pc_i
redirect_pc_i  in  XLEN  corrected target (JALR already masked bit0)
upd_valid_i  in  1  BTB update strobe from EX (branch/jump resolved)
upd_pc_i  in  XLEN  PC of resolved control instruction
upd_taken_i  in  1  resolved direction
upd_target_i  in  XLEN  resolved target
pc_o  out  XLEN  current fetch PC
pc_plus4_o  out  XLEN  pc_o + 4, modulo 2^XLEN
fetch_valid_o  out  1  pc_o is a valid fetch
pred_taken_o  out  1  BTB predicts taken for pc_o
pred_target_o  out  XLEN  predicted target for pc_o
misalign_o  out  1  fault: redirect target not 4-byte aligned

Behaviour:
- Reset (async) values: pc_o=RESET_VECTOR; fetch_valid_o=0; misalign_o=0; FSM=BOOT; all BTB valid bits cleared, so pred_taken_o=0. Counters and targets are don't-care.
- FSM states:
  - BOOT: fetch_valid_o=0; PC holds. Next edge: RUN.
  - RUN: fetch_valid_o=1.
  - FAULT: fetch_valid_o=0; misalign_o=1.
- Transitions:
  - Aligned redirect (redirect_pc_i[1:0]==0) in any state: PC<=target; go to RUN.
  - Misaligned redirect: PC<=target; go to FAULT.
  - FAULT exits only on an aligned redirect.
- Next-PC priority in RUN:
  1. redirect_i
  2. stall_i: hold PC
  3. pred_taken_o: PC<=pred_target_o
  4. otherwise PC<=pc_o+4
- Redirect overrides stall. Stall and prediction are ignored in BOOT and FAULT; PC holds there.
- Latency: one cycle from redirect_i to pc_o=target. No combinational path from redirect_i to pc_o.
- BTB indexing: index = pc[log2(BTB_ENTRIES)+1:2]; tag = pc[XLEN-1:log2(BTB_ENTRIES)+2].
- BTB lookup is combinational on pc_o. Hit = valid and tag match. pred_taken_o = hit and ctr[1]. pred_target_o = entry target; on a miss it is pc_plus4_o.
- BTB update, at the clock edge when upd_valid_i=1:
  - Hit: ctr saturating +1 if taken, -1 if not taken (bounds 0 and 3). Target rewritten only when taken.
  - Miss and taken: allocate/overwrite the entry; valid=1, tag, target, ctr=2'b10.
  - Miss and not taken: no change.
- Updates are accepted during stall, BOOT and FAULT.
- A same-cycle lookup of the updated entry sees the old contents.
- During stall, pred_* may change when an update hits the stalled PC's index.
- Wrap-around: 0xFFFF_FFFC + 4 = 0x0000_0000, with no flag.
- Reset mid-run: immediate return to the reset values.

Decomposition:
- Package rv_pc_pkg:
  - FSM enum {BOOT, RUN, FAULT}
  - btb_entry_t struct {valid, tag, target, ctr[1:0]}
  - ctr constants WEAK_TAKEN=2'b10, SAT_MAX=2'b11
- Sub-module pc_btb:
  - storage array, lookup, update and saturating counter logic
  - parametrised by XLEN and BTB_ENTRIES
- The top level holds the FSM, PC register and next-PC mux.

Test Plan:
- Reset then release: cycle1 pc=0x0, valid=0; cycle2 pc=0x0, valid=1; cycle3 pc=0x4; cycle4 pc=0x8.
- Stall at pc=0x8 for 3 cycles: pc stays 0x8 and valid=1 throughout; release gives 0xC on the next cycle.
- Stall and redirect to 0x100 in the same cycle at pc=0x10: next pc=0x100.
- BTB update (0x20, taken, 0x80), then run to 0x20: pred_taken_o=1, pred_target_o=0x80, next pc=0x80. One not-taken update (ctr 10->01), rerun: pred_taken_o=0, next pc=0x24.
- Redirect 0x102: next cycle misalign_o=1, valid=0, pc holds 0x102 under stall_i=0. Then redirect 0x200: misalign_o=0, valid=1, pc=0x200, next 0x204.
- Redirect 0xFFFF_FFFC: pc_plus4_o=0x0 and next pc=0x0. Assert rst asynchronously mid-cycle: pc_o=RESET_VECTOR and valid=0 immediately, and a previously trained entry no longer predicts.
